// File: rtl/beta_test_sequencer.sv
// Run controller for the pipelined beta core: load imem, run to halt PC, read back and compare a dm window.
// Optional RUN watchdog is compiled in when BETA_SEQ_WATCHDOG_EN is defined.
module beta_test_sequencer #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NCHK       = 4,
  parameter int DA_W       = 32,
  parameter int CHK_BASE   = 0,
  parameter int TIMEOUT    = 1024,
  localparam int IA_W      = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   ld_valid,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   imem_we,
  output logic [IA_W-1:0]        imem_addr,
  output logic [DATA_W-1:0]      imem_wdata,
  output logic                   cpu_reset,
  input  logic [PC_W-1:0]        cpu_pc,
  input  logic [PC_W-1:0]        halt_pc,
  output logic [DA_W-1:0]        dm_addr,
  input  logic [DATA_W-1:0]      dm_rdata,
  input  logic [NCHK*DATA_W-1:0] exp_data,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout_err,
  output logic [3:0]             fail_idx,
  output logic [31:0]            cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [IA_W-1:0]   ptr;
  logic [4:0]        chk_idx;
  logic [4:0]        cmp_idx;
  logic              mism;
  logic              pass_q;
  logic [3:0]        fail_idx_q;
  logic [31:0]       cc;
  logic [31:0]       cc_next;
  logic [DATA_W-1:0] exp_word;
  logic              word_mism;
  logic              halt_hit;
`ifdef BETA_SEQ_WATCHDOG_EN
  logic              timeout_q;
`endif

  // Load handshake: a word transfers on every cycle where ld_valid && ld_ready;
  // ld_ready is high for the whole LOAD state and drops after the final accepted word.
  assign ld_ready   = (state == S_LOAD);
  assign imem_we    = ld_ready && ld_valid;
  assign imem_addr  = ptr;
  assign imem_wdata = ld_data;
  assign cpu_reset  = (state != S_RUN);
  assign done       = (state == S_DONE);
  assign pass       = pass_q;
  assign fail_idx   = fail_idx_q;
  assign cycle_count = cc;
`ifdef BETA_SEQ_WATCHDOG_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cc_next  = (cc == 32'hFFFF_FFFF) ? cc : cc + 32'd1;
  assign halt_hit = (cpu_pc == halt_pc);

  // chk_idx k issues the read of word k; dm_rdata for word k-1 arrives in the same cycle.
  assign cmp_idx = chk_idx - 5'd1;
  assign dm_addr = (state == S_CHECK && chk_idx < 5'(NCHK))
                   ? DA_W'(CHK_BASE) + DA_W'(chk_idx) : '0;

  always_comb begin
    exp_word = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (cmp_idx == 5'(i)) exp_word = exp_data[i*DATA_W +: DATA_W];
    end
  end

  assign word_mism = (chk_idx != 5'd0) && (dm_rdata != exp_word);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      ptr        <= '0;
      chk_idx    <= '0;
      mism       <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      cc         <= '0;
`ifdef BETA_SEQ_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            ptr        <= '0;
            chk_idx    <= '0;
            mism       <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            cc         <= '0;
`ifdef BETA_SEQ_WATCHDOG_EN
            timeout_q  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + 1'b1;
            if (ld_last || ptr == IA_W'(IMEM_DEPTH - 1)) state <= S_RUN;
          end
        end
        S_RUN: begin
          cc <= cc_next;
          if (halt_hit) begin
            state   <= S_CHECK;
            chk_idx <= '0;
            mism    <= 1'b0;
          end
`ifdef BETA_SEQ_WATCHDOG_EN
          else if (cc_next >= 32'(TIMEOUT)) begin
            state     <= S_DONE;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
`endif
        end
        S_CHECK: begin
          chk_idx <= chk_idx + 5'd1;
          // Only the first mismatching word is recorded.
          if (word_mism && !mism) fail_idx_q <= cmp_idx[3:0];
          if (word_mism) mism <= 1'b1;
          if (chk_idx == 5'(NCHK)) begin
            state  <= S_DONE;
            pass_q <= !(mism || word_mism);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
